mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 38 +++
 rtl/mem_access.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: word-oriented data-memory port between the mem_access
// stage (master) and the data memory (slave).
//
// Handshake: the master raises mem_req_o together with mem_we_o, mem_addr_o,
// mem_be_o and mem_wdata_o, and holds all of them stable until the slave
// signals completion by driving mem_ack_i high for one rising edge. A read
// returns its word on mem_rdata_i in the same cycle as mem_ack_i. The
// master samples mem_ack_i only while a request is outstanding.
//
// Signals (named from the master's point of view):
//   mem_req_o    request outstanding
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   word-aligned byte address, ADDR_W bits
//   mem_be_o     little-endian byte lane enables
//   mem_wdata_o  write data, already replicated onto the active lanes
//   mem_ack_i    completion strobe from the memory
//   mem_rdata_i  read word from the memory
interface mem_access_if #(
  parameter int ADDR_W = 17
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: pipeline memory-access stage. Non-memory results pass
// through with one cycle of latency. Aligned loads/stores are issued to
// the data memory and the stage stalls upstream until the memory
// acknowledges; the load result is lane-selected and extended. Misaligned
// accesses are not issued and are flagged with misalign_o for one cycle.
//
// Ports:
//   dclk            clock, rising edge
//   rst             asynchronous active-low reset
//   valid_i         EX result valid
//   memop_i         0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW (9-15 NONE)
//   addr_i          effective byte address
//   storedata_i     store source value
//   wreg_i/waddr_i  register write enable / destination
//   wdata_i         ALU result for non-memory ops
//   stall_req_o     combinational upstream hold
//   valid_o, wreg_o, waddr_o, wdata_o, misalign_o  registered results
//   state_o         current FSM state (0 IDLE, 1 WAIT)
//   mem             memory port (master side of mem_access_if)
module mem_access #(
  parameter int ADDR_W = 17
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] storedata_i,
  input  logic        wreg_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_req_o,
  output logic        valid_o,
  output logic        wreg_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [0:0]  state_o,
  mem_access_if.master mem
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        state_q,  state_d;
  logic              req_q,    req_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] maddr_q,  maddr_d;
  logic [3:0]        be_q,     be_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic              valid_q,  valid_d;
  logic              wreg_q,   wreg_d;
  logic [4:0]        waddr_q,  waddr_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic              mis_q,    mis_d;
  // Operation context captured at issue, consumed on the ack edge.
  logic [3:0]        op_q,     op_d;
  logic              lwreg_q,  lwreg_d;
  logic [4:0]        lwaddr_q, lwaddr_d;
  logic [1:0]        off_q,    off_d;

  logic        is_mem;
  logic        aligned;
  logic        is_store;
  logic        is_load_q;
  logic [3:0]  be_new;
  logic [31:0] mwdata_new;
  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  // Address bits above the memory port width have no destination.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W];

  assign is_mem   = valid_i && (memop_i >= OP_LB) && (memop_i <= OP_SW);
  assign is_store = (memop_i == OP_SB) || (memop_i == OP_SH) || (memop_i == OP_SW);

  always_comb begin
    aligned    = 1'b1;
    be_new     = 4'b0000;
    mwdata_new = 32'h0;
    case (memop_i)
      OP_LB, OP_LBU, OP_SB: begin
        be_new     = 4'b0001 << addr_i[1:0];
        mwdata_new = {4{storedata_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        aligned    = ~addr_i[0];
        be_new     = 4'b0011 << {addr_i[1], 1'b0};
        mwdata_new = {2{storedata_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        aligned    = (addr_i[1:0] == 2'b00);
        be_new     = 4'b1111;
        mwdata_new = storedata_i;
      end
      default: ;
    endcase
    // Loads leave the write-data bus at zero; only stores carry data.
    if (!is_store) mwdata_new = 32'h0;
  end

  // Lane selection for the load result, driven by the latched offset.
  assign rshift    = mem.mem_rdata_i >> {off_q, 3'b000};
  assign rbyte     = rshift[7:0];
  assign rhalf     = off_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
  assign is_load_q = (op_q >= OP_LB) && (op_q <= OP_LHU);

  always_comb begin
    case (op_q)
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'h0, rbyte};
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'h0, rhalf};
      OP_LW:   load_data = mem.mem_rdata_i;
      default: load_data = 32'h0;
    endcase
  end

  // In WAIT the stall drops in the ack cycle so upstream advances on the
  // same edge that completes the access and the op is never reissued.
  always_comb begin
    stall_req_o = 1'b0;
    if (rst) begin
      if (state_q == ST_IDLE) stall_req_o = is_mem && aligned;
      else                    stall_req_o = ~mem.mem_ack_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    mwdata_d = mwdata_q;
    valid_d  = valid_q;
    wreg_d   = wreg_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    mis_d    = 1'b0;
    op_d     = op_q;
    lwreg_d  = lwreg_q;
    lwaddr_d = lwaddr_q;
    off_d    = off_q;
    if (state_q == ST_IDLE) begin
      if (is_mem && aligned) begin
        state_d  = ST_WAIT;
        req_d    = 1'b1;
        we_d     = is_store;
        maddr_d  = {addr_i[ADDR_W-1:2], 2'b00};
        be_d     = be_new;
        mwdata_d = mwdata_new;
        valid_d  = 1'b0;
        wreg_d   = 1'b0;
        op_d     = memop_i;
        lwreg_d  = wreg_i;
        lwaddr_d = waddr_i;
        off_d    = addr_i[1:0];
      end else if (is_mem) begin
        // Misaligned: retire immediately with no write-back.
        valid_d = 1'b1;
        wreg_d  = 1'b0;
        waddr_d = waddr_i;
        wdata_d = 32'h0;
        mis_d   = 1'b1;
      end else if (valid_i) begin
        valid_d = 1'b1;
        wreg_d  = wreg_i;
        waddr_d = waddr_i;
        wdata_d = wdata_i;
      end else begin
        valid_d = 1'b0;
        wreg_d  = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
      if (mem.mem_ack_i) begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b1;
        wreg_d  = is_load_q && lwreg_q;
        waddr_d = lwaddr_q;
        wdata_d = load_data;
      end
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= 4'b0000;
      mwdata_q <= 32'h0;
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'h0;
      mis_q    <= 1'b0;
      op_q     <= 4'd0;
      lwreg_q  <= 1'b0;
      lwaddr_q <= 5'd0;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      op_q     <= op_d;
      lwreg_q  <= lwreg_d;
      lwaddr_q <= lwaddr_d;
      off_q    <= off_d;
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = maddr_q;
  assign mem.mem_be_o    = be_q;
  assign mem.mem_wdata_o = mwdata_q;
  assign valid_o         = valid_q;
  assign wreg_o          = wreg_q;
  assign waddr_o         = waddr_q;
  assign wdata_o         = wdata_q;
  assign misalign_o      = mis_q;
  assign state_o         = state_q;

endmodule
